issue_select: RTL and testbench
===============================

ISSUE_SELECT -- requirements
Module: issue_select

Interface
REQ-001 Parameter QUEUE_LEN, default 8, number of issue-queue entries arbitrated.
REQ-002 Parameter READ_NUM, default 2, number of issue ports (grants per cycle).
REQ-003 Parameter WRITE_NUM, default 2, number of allocation ports per cycle.
REQ-004 Parameter BUSY_CYCLES, default 0, extra cycles each port is blocked after a grant (0 = fully pipelined unit).
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 resetn  in  1  reset, asynchronous, active-low.
REQ-007 flush  in  1  pipeline flush; clears all scheduling state.
REQ-008 alloc_valid  in  WRITE_NUM  allocation port i writes an entry this cycle.
REQ-009 alloc_idx  in  WRITE_NUM x clog2(QUEUE_LEN)  entry index written by port i.
REQ-010 occupied  in  QUEUE_LEN  entry holds a valid, not-yet-issued instruction (state before this cycle's allocation).
REQ-011 ready  in  QUEUE_LEN  both sources of the entry are available (from wakeup).
REQ-012 stall  in  1  execute register not accepting; no new grants.
REQ-013 grant_valid  out  READ_NUM  registered grant on issue port p.
REQ-014 grant_idx  out  READ_NUM x clog2(QUEUE_LEN)  registered entry index granted on port p.
REQ-015 port_busy  out  READ_NUM  port p is blocked by its busy counter.

Function
REQ-016 Age is held in a QUEUE_LEN x QUEUE_LEN age matrix; older[i][j]=1 means entry j is older than entry i.
REQ-017 On allocation of entry i, row i is loaded with occupied, OR'd with the one-hot indices of lower-numbered alloc ports valid in the same cycle; column i is cleared in all other rows.
REQ-018 Candidate set = occupied AND ready AND NOT (entries granted last cycle and still occupied); entries allocated this cycle are not candidates.
REQ-019 Port 0 selects the oldest candidate (the candidate with no older candidate); port p selects the oldest candidate remaining after ports 0..p-1 are removed.
REQ-020 Ports whose port_busy is high are skipped: the next free port takes the next-oldest candidate.
REQ-021 Selection is combinational; grant_valid/grant_idx are registered, so latency from ready to grant output is 1 cycle.
REQ-022 When stall is high, grant_valid and grant_idx hold their values, no busy counter loads, age matrix still updates for allocations.
REQ-023 Fewer candidates than free ports: remaining ports drive grant_valid=0, grant_idx=0.
REQ-024 Busy counter per port, width clog2(BUSY_CYCLES+1); loaded with BUSY_CYCLES on a registered grant, decremented to 0 saturating; port_busy = counter != 0.
REQ-025 Same entry never granted on two ports in one cycle; grant indices within a cycle are distinct.
REQ-026 flush: next cycle grant_valid=0, busy counters=0, age matrix=0; allocations in the flush cycle are ignored.
REQ-027 Allocation to an index marked occupied is illegal; bench flags it as an assertion failure.

Reset
REQ-028 While resetn=0: grant_valid=0, grant_idx=0, port_busy=0, all busy counters=0, age matrix=0, taking effect immediately (asynchronous).
REQ-029 First grant can appear on the second rising edge after resetn deasserts, given a ready occupied entry.

Structure
REQ-030 Shared package issue_queue_pkg holds QUEUE_LEN/READ_NUM/WRITE_NUM defaults and the entry-index typedef.
REQ-031 One sub-module, age_matrix, holds the matrix, its allocation update and the per-candidate "oldest" vector; selection and busy counters stay in issue_select.

Verification
REQ-032 Alloc entries 3 then 5 (separate cycles), both ready -> next cycle port0 grant_idx=3, port1 grant_idx=5.
REQ-033 Same-cycle alloc port0 idx 6, port1 idx 1, both ready -> port0 grants 6, port1 grants 1.
REQ-034 BUSY_CYCLES=2, three ready entries, port0 granted -> port_busy[0] high 2 cycles; intervening grants only on port1.
REQ-035 stall high 3 cycles with ready entries -> grants frozen at prior value; after stall drops, oldest candidate granted.
REQ-036 flush with 4 occupied entries -> grant_valid=0 next cycle; age matrix reads 0.
REQ-037 Assert resetn low mid-grant -> grant_valid and port_busy drop to 0 without a clock edge.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared sizing defaults and entry-index type for the issue-queue scheduler.
package issue_queue_pkg;
  localparam int DEF_QUEUE_LEN = 8;
  localparam int DEF_READ_NUM  = 2;
  localparam int DEF_WRITE_NUM = 2;
  localparam int DEF_IDX_W     = $clog2(DEF_QUEUE_LEN);

  typedef logic [DEF_IDX_W-1:0] entry_idx_t;
endpackage

// File: rtl/age_matrix.sv
// Age matrix: r_older[i][j]=1 when entry j is older than entry i.
// Emits, for each rank k, the one-hot candidate that has exactly k older candidates.
module age_matrix
  import issue_queue_pkg::*;
#(
  parameter int QUEUE_LEN = DEF_QUEUE_LEN,
  parameter int WRITE_NUM = DEF_WRITE_NUM,
  parameter int RANKS     = DEF_READ_NUM,
  localparam int IDX_W    = $clog2(QUEUE_LEN)
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            i_flush,
  input  logic [WRITE_NUM-1:0]            i_alloc_valid,
  input  logic [WRITE_NUM-1:0][IDX_W-1:0] i_alloc_idx,
  input  logic [QUEUE_LEN-1:0]            i_occupied,
  input  logic [QUEUE_LEN-1:0]            i_cand,
  output logic [RANKS-1:0][QUEUE_LEN-1:0] o_kth_oldest
);
  localparam int RANK_W = IDX_W + 1;

  logic [QUEUE_LEN-1:0][QUEUE_LEN-1:0] r_older;
  logic [QUEUE_LEN-1:0][QUEUE_LEN-1:0] w_older_nxt;
  logic [QUEUE_LEN-1:0][QUEUE_LEN-1:0] w_row_load;
  logic [QUEUE_LEN-1:0]                w_alloc_mask;
  logic [QUEUE_LEN-1:0][RANK_W-1:0]    w_rank;

  always_comb begin
    w_alloc_mask = '0;
    w_row_load   = '0;
    // Lower-numbered ports allocating in the same cycle count as older.
    for (int k = 0; k < WRITE_NUM; k++) begin
      if (i_alloc_valid[k]) begin
        w_row_load[i_alloc_idx[k]]   = i_occupied | w_alloc_mask;
        w_alloc_mask[i_alloc_idx[k]] = 1'b1;
      end
    end
    for (int r = 0; r < QUEUE_LEN; r++) begin
      w_older_nxt[r] = w_alloc_mask[r] ? w_row_load[r] : (r_older[r] & ~w_alloc_mask);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_older <= '0;
    end else if (i_flush) begin
      r_older <= '0;
    end else begin
      r_older <= w_older_nxt;
    end
  end

  always_comb begin
    w_rank = '0;
    for (int i = 0; i < QUEUE_LEN; i++) begin
      for (int j = 0; j < QUEUE_LEN; j++) begin
        w_rank[i] = w_rank[i] + RANK_W'(r_older[i][j] & i_cand[j]);
      end
    end
  end

  always_comb begin
    o_kth_oldest = '0;
    for (int k = 0; k < RANKS; k++) begin
      for (int i = 0; i < QUEUE_LEN; i++) begin
        o_kth_oldest[k][i] = i_cand[i] & (w_rank[i] == RANK_W'(k));
      end
    end
  end
endmodule

// File: rtl/issue_select.sv
// Oldest-first multi-port issue selection with registered grants and
// per-port busy counters for non-pipelined execution units.
module issue_select
  import issue_queue_pkg::*;
#(
  parameter int QUEUE_LEN   = DEF_QUEUE_LEN,
  parameter int READ_NUM    = DEF_READ_NUM,
  parameter int WRITE_NUM   = DEF_WRITE_NUM,
  parameter int BUSY_CYCLES = 0,
  localparam int IDX_W      = $clog2(QUEUE_LEN)
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            flush,
  input  logic [WRITE_NUM-1:0]            alloc_valid,
  input  logic [WRITE_NUM-1:0][IDX_W-1:0] alloc_idx,
  input  logic [QUEUE_LEN-1:0]            occupied,
  input  logic [QUEUE_LEN-1:0]            ready,
  input  logic                            stall,
  output logic [READ_NUM-1:0]             grant_valid,
  output logic [READ_NUM-1:0][IDX_W-1:0]  grant_idx,
  output logic [READ_NUM-1:0]             port_busy
);
  localparam int BUSY_W = (BUSY_CYCLES > 0) ? $clog2(BUSY_CYCLES + 1) : 1;

  logic [READ_NUM-1:0]                r_grant_valid;
  logic [READ_NUM-1:0][IDX_W-1:0]     r_grant_idx;
  logic [READ_NUM-1:0][BUSY_W-1:0]    r_busy_cnt;
  logic [QUEUE_LEN-1:0]               w_granted;
  logic [QUEUE_LEN-1:0]               w_alloc_mask;
  logic [QUEUE_LEN-1:0]               w_cand;
  logic [READ_NUM-1:0][QUEUE_LEN-1:0] w_kth;
  logic [READ_NUM-1:0]                w_sel_valid;
  logic [READ_NUM-1:0][IDX_W-1:0]     w_sel_idx;

  function automatic logic [IDX_W-1:0] oh2idx(input logic [QUEUE_LEN-1:0] oh);
    oh2idx = '0;
    for (int i = 0; i < QUEUE_LEN; i++) begin
      if (oh[i]) oh2idx = oh2idx | IDX_W'(i);
    end
  endfunction

  // Entries on the grant register are still marked occupied for one cycle.
  always_comb begin
    w_granted    = '0;
    w_alloc_mask = '0;
    for (int p = 0; p < READ_NUM; p++) begin
      if (r_grant_valid[p]) w_granted[r_grant_idx[p]] = 1'b1;
    end
    for (int k = 0; k < WRITE_NUM; k++) begin
      if (alloc_valid[k]) w_alloc_mask[alloc_idx[k]] = 1'b1;
    end
    w_cand = occupied & ready & ~(w_granted & occupied) & ~w_alloc_mask;
  end

  age_matrix #(
    .QUEUE_LEN (QUEUE_LEN),
    .WRITE_NUM (WRITE_NUM),
    .RANKS     (READ_NUM)
  ) u_age (
    .clk           (clk),
    .resetn        (resetn),
    .i_flush       (flush),
    .i_alloc_valid (alloc_valid),
    .i_alloc_idx   (alloc_idx),
    .i_occupied    (occupied),
    .i_cand        (w_cand),
    .o_kth_oldest  (w_kth)
  );

  // The n-th free port takes the n-th oldest candidate.
  always_comb begin
    int n;
    n           = 0;
    w_sel_valid = '0;
    w_sel_idx   = '0;
    for (int p = 0; p < READ_NUM; p++) begin
      if (!port_busy[p]) begin
        for (int k = 0; k < READ_NUM; k++) begin
          if (k == n && |w_kth[k]) begin
            w_sel_valid[p] = 1'b1;
            w_sel_idx[p]   = oh2idx(w_kth[k]);
          end
        end
        n++;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_grant_valid <= '0;
      r_grant_idx   <= '0;
      r_busy_cnt    <= '0;
    end else if (flush) begin
      r_grant_valid <= '0;
      r_grant_idx   <= '0;
      r_busy_cnt    <= '0;
    end else begin
      if (!stall) begin
        r_grant_valid <= w_sel_valid;
        r_grant_idx   <= w_sel_idx;
      end
      for (int p = 0; p < READ_NUM; p++) begin
        if (!stall && w_sel_valid[p]) begin
          r_busy_cnt[p] <= BUSY_W'(BUSY_CYCLES);
        end else if (r_busy_cnt[p] != '0) begin
          r_busy_cnt[p] <= r_busy_cnt[p] - BUSY_W'(1);
        end
      end
    end
  end

  always_comb begin
    port_busy = '0;
    for (int p = 0; p < READ_NUM; p++) begin
      port_busy[p] = (r_busy_cnt[p] != '0);
    end
  end

  assign grant_valid = r_grant_valid;
  assign grant_idx   = r_grant_idx;
endmodule

// File: tb/tb_issue_select.sv
// Scoreboard bench for issue_select: an allocation-order list model predicts
// each cycle's registered grants; a monitor compares them after every edge.
module tb_issue_select;
  localparam int QL = 8;
  localparam int RN = 2;
  localparam int WN = 2;
  localparam int BC = 2;
  localparam int IW = 3;

  logic                   clk = 1'b0;
  logic                   resetn = 1'b1;
  logic                   flush = 1'b0;
  logic                   stall = 1'b0;
  logic [WN-1:0]          alloc_valid = '0;
  logic [WN-1:0][IW-1:0]  alloc_idx = '0;
  logic [QL-1:0]          occupied = '0;
  logic [QL-1:0]          ready = '0;
  logic [RN-1:0]          grant_valid;
  logic [RN-1:0][IW-1:0]  grant_idx;
  logic [RN-1:0]          port_busy;

  issue_select #(
    .QUEUE_LEN   (QL),
    .READ_NUM    (RN),
    .WRITE_NUM   (WN),
    .BUSY_CYCLES (BC)
  ) u_dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .alloc_idx   (alloc_idx),
    .occupied    (occupied),
    .ready       (ready),
    .stall       (stall),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .port_busy   (port_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RN-1:0]         gv;
    logic [RN-1:0][IW-1:0] gi;
    logic [RN-1:0]         busy;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  string phase = "reset";

  // Reference model state: allocation order, expected grant register, busy counts.
  int            age_q[$];
  bit            m_gv[RN];
  int            m_gi[RN];
  int            m_cnt[RN];
  logic [QL-1:0] occ;
  logic [QL-1:0] rdy;

  int            freel[$];
  int            a_r[WN];
  logic [WN-1:0] av_r;
  logic          st_r, fl_r;
  int            pick;

  function automatic void check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s [%s]: got %0d, expected %0d", name, phase, act, req);
  endfunction

  task automatic model_reset();
    for (int p = 0; p < RN; p++) begin
      m_gv[p]  = 1'b0;
      m_gi[p]  = 0;
      m_cnt[p] = 0;
    end
    age_q.delete();
    exp_q.delete();
    occ = '0;
  endtask

  // One clock: drive inputs at negedge, predict, push, let the edge pass.
  task automatic step(input logic [WN-1:0] av, input int a0, input int a1,
                      input logic st, input logic fl);
    logic [QL-1:0] amask, gmask, freem;
    int            ai[WN];
    int            cl[$];
    int            n;
    exp_t          e;
    ai[0] = a0;
    ai[1] = a1;
    amask = '0;
    gmask = '0;
    for (int k = 0; k < WN; k++) if (av[k]) amask[ai[k]] = 1'b1;
    for (int p = 0; p < RN; p++) if (m_gv[p]) gmask[m_gi[p]] = 1'b1;
    freem = st ? '0 : gmask;

    alloc_valid  = av;
    alloc_idx[0] = IW'(a0);
    alloc_idx[1] = IW'(a1);
    stall        = st;
    flush        = fl;
    occupied     = occ;
    ready        = rdy;

    if (fl) begin
      for (int p = 0; p < RN; p++) begin
        m_gv[p]  = 1'b0;
        m_gi[p]  = 0;
        m_cnt[p] = 0;
      end
      age_q.delete();
    end else begin
      foreach (age_q[i]) begin
        if (occ[age_q[i]] && rdy[age_q[i]] && !gmask[age_q[i]] && !amask[age_q[i]])
          cl.push_back(age_q[i]);
      end
      n = 0;
      for (int p = 0; p < RN; p++) begin
        if (st) begin
          if (m_cnt[p] > 0) m_cnt[p]--;
        end else if (m_cnt[p] > 0) begin
          m_gv[p] = 1'b0;
          m_gi[p] = 0;
          m_cnt[p]--;
        end else if (n < cl.size()) begin
          m_gv[p]  = 1'b1;
          m_gi[p]  = cl[n];
          m_cnt[p] = BC;
          n++;
        end else begin
          m_gv[p] = 1'b0;
          m_gi[p] = 0;
        end
      end
      for (int k = 0; k < WN; k++) begin
        if (av[k]) begin
          for (int i = age_q.size() - 1; i >= 0; i--) if (age_q[i] == ai[k]) age_q.delete(i);
          age_q.push_back(ai[k]);
        end
      end
    end

    for (int p = 0; p < RN; p++) begin
      e.gv[p]   = m_gv[p];
      e.gi[p]   = IW'(m_gi[p]);
      e.busy[p] = (m_cnt[p] != 0);
    end
    exp_q.push_back(e);

    @(posedge clk);
    if (fl) occ = '0;
    else occ = (occ & ~freem) | amask;
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    rdy = '0;
    for (int c = 0; c < cycles; c++) step('0, 0, 0, 1'b0, 1'b0);
  endtask

  // Monitor: compare DUT outputs against the queued prediction after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant_valid", int'(grant_valid), int'(e.gv));
        check("grant_idx", int'(grant_idx), int'(e.gi));
        check("port_busy", int'(port_busy), int'(e.busy));
        if (grant_valid == 2'b11)
          check("grant_distinct", int'(grant_idx[0] != grant_idx[1]), 1);
      end
    end
  end

  // Allocating into an occupied slot is illegal.
  always @(posedge clk) begin
    if (resetn) begin
      for (int k = 0; k < WN; k++) begin
        assert (!(alloc_valid[k] && occupied[alloc_idx[k]]))
          else $error("FAIL alloc_to_occupied: idx %0d already occupied", alloc_idx[k]);
      end
    end
  end

  initial begin
    rdy = '0;
    model_reset();
    #1 resetn = 1'b0;
    #1;
    check("reset_grant_valid", int'(grant_valid), 0);
    check("reset_grant_idx", int'(grant_idx), 0);
    check("reset_port_busy", int'(port_busy), 0);
    check("reset_age_zero", int'(u_dut.u_age.r_older == '0), 1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    phase = "alloc_3_then_5";
    rdy = '0;
    step(2'b01, 3, 0, 1'b0, 1'b0);
    step(2'b01, 5, 0, 1'b0, 1'b0);
    rdy = '1;
    step('0, 0, 0, 1'b0, 1'b0);
    check("t32_gv", int'(grant_valid), 3);
    check("t32_port0", int'(grant_idx[0]), 3);
    check("t32_port1", int'(grant_idx[1]), 5);
    idle(3);

    phase = "same_cycle_6_1";
    step(2'b11, 6, 1, 1'b0, 1'b0);
    rdy = '1;
    step('0, 0, 0, 1'b0, 1'b0);
    check("t33_port0", int'(grant_idx[0]), 6);
    check("t33_port1", int'(grant_idx[1]), 1);
    idle(3);

    phase = "busy_port0";
    step(2'b11, 0, 2, 1'b0, 1'b0);
    step(2'b01, 4, 0, 1'b0, 1'b0);
    rdy = 8'h01;
    step('0, 0, 0, 1'b0, 1'b0);
    check("t34_c1_gv", int'(grant_valid), 1);
    check("t34_c1_busy", int'(port_busy), 1);
    rdy = 8'h14;
    step('0, 0, 0, 1'b0, 1'b0);
    check("t34_c2_gv", int'(grant_valid), 2);
    check("t34_c2_port1", int'(grant_idx[1]), 2);
    check("t34_c2_busy", int'(port_busy), 3);
    step('0, 0, 0, 1'b0, 1'b0);
    check("t34_c3_gv", int'(grant_valid), 0);
    check("t34_c3_busy0", int'(port_busy[0]), 0);
    step('0, 0, 0, 1'b0, 1'b0);
    check("t34_c4_port0", int'(grant_idx[0]), 4);
    idle(3);

    phase = "stall";
    step(2'b11, 1, 3, 1'b0, 1'b0);
    step(2'b01, 5, 0, 1'b0, 1'b0);
    rdy = '1;
    step('0, 0, 0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step('0, 0, 0, 1'b1, 1'b0);
      check("t35_hold_gv", int'(grant_valid), 3);
      check("t35_hold_port0", int'(grant_idx[0]), 1);
      check("t35_hold_port1", int'(grant_idx[1]), 3);
    end
    step('0, 0, 0, 1'b0, 1'b0);
    check("t35_after_gv", int'(grant_valid), 1);
    check("t35_after_port0", int'(grant_idx[0]), 5);
    idle(3);

    phase = "flush";
    step(2'b11, 0, 2, 1'b0, 1'b0);
    step(2'b11, 4, 6, 1'b0, 1'b0);
    rdy = '1;
    step(2'b01, 7, 0, 1'b0, 1'b1);
    check("t36_gv", int'(grant_valid), 0);
    check("t36_busy", int'(port_busy), 0);
    check("t36_age_zero", int'(u_dut.u_age.r_older == '0), 1);
    idle(2);

    phase = "async_reset";
    step(2'b01, 2, 0, 1'b0, 1'b0);
    rdy = '1;
    step('0, 0, 0, 1'b0, 1'b0);
    check("t37_pre_gv", int'(grant_valid), 1);
    #3 resetn = 1'b0;
    #1;
    check("t37_gv", int'(grant_valid), 0);
    check("t37_idx", int'(grant_idx), 0);
    check("t37_busy", int'(port_busy), 0);
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    phase = "random";
    for (int c = 0; c < 500; c++) begin
      rdy = QL'($urandom);
      av_r = '0;
      a_r[0] = 0;
      a_r[1] = 0;
      freel.delete();
      for (int e = 0; e < QL; e++) if (!occ[e]) freel.push_back(e);
      for (int k = 0; k < WN; k++) begin
        if (freel.size() > 0 && $urandom_range(0, 2) != 0) begin
          pick = int'($urandom_range(0, freel.size() - 1));
          a_r[k] = freel[pick];
          av_r[k] = 1'b1;
          freel.delete(pick);
        end
      end
      st_r = ($urandom_range(0, 9) == 0);
      fl_r = ($urandom_range(0, 49) == 0);
      step(av_r, a_r[0], a_r[1], st_r, fl_r);
    end
    flush = 1'b0;
    stall = 1'b0;
    alloc_valid = '0;

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
